dmem_ctrl: RTL and testbench

Load/store controller that sits between the CPU datapath and the data memory and acts as the initiator on the data-memory port. It accepts one byte or halfword load/store request at a time from the CPU and sequences it into single-byte writes and registered reads on the memory port. Results are returned through a one-cycle response pulse. Halfwords are split into two byte accesses at addr and addr+1, because the memory write port is 8 bits wide and only the low byte of each read entry is meaningful.

---
 rtl/dmem_ctrl.sv | 117 +++++++++++
 tb/tb_dmem_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte/halfword load-store sequencer driving an 8-bit-write data memory port.
module dmem_ctrl #(
  parameter int ADDR_W        = 16,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  output logic [15:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [15:0]       mem_rdata
);
  typedef enum logic [2:0] {IDLE, ST0, ST1, LD0, LD1, LD2, RESP} state_t;
  state_t            state_q, state_d;
  logic              size_q, size_d, signed_q, signed_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr1;
  logic [15:0]       wdata_q, wdata_d, resp_rdata_q, resp_rdata_d;
  logic [7:0]        b0_q, b0_d, hi_byte;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d, mem_re_q, mem_re_d;
  assign addr1      = addr_q + 1'b1;
  assign hi_byte    = LITTLE_ENDIAN ? wdata_q[15:8] : wdata_q[7:0];
  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign mem_re     = mem_re_q;
  // Memory-port signals are computed for the state being entered so they are flop outputs.
  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    signed_d     = signed_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    b0_d         = b0_q;
    resp_rdata_d = resp_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    mem_re_d     = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        size_d      = req_size;
        signed_d    = req_signed;
        addr_d      = req_addr;
        wdata_d     = req_wdata;
        state_d     = req_we ? ST0 : LD0;
        mem_we_d    = req_we;
        mem_re_d    = !req_we;
        mem_addr_d  = req_addr;
        mem_wdata_d = req_we ? (LITTLE_ENDIAN ? req_wdata[7:0] : req_wdata[15:8]) : mem_wdata_q;
      end
      ST0: begin
        state_d     = size_q ? ST1 : RESP;
        mem_we_d    = size_q;
        mem_addr_d  = size_q ? addr1 : mem_addr_q;
        mem_wdata_d = size_q ? hi_byte : mem_wdata_q;
      end
      ST1: state_d = RESP;
      LD0: begin
        state_d    = LD1;
        mem_re_d   = size_q;
        mem_addr_d = size_q ? addr1 : mem_addr_q;
      end
      LD1: begin
        b0_d         = mem_rdata[7:0];
        state_d      = size_q ? LD2 : RESP;
        resp_rdata_d = size_q ? resp_rdata_q : {{8{mem_rdata[7] & signed_q}}, mem_rdata[7:0]};
      end
      LD2: begin
        state_d      = RESP;
        resp_rdata_d = LITTLE_ENDIAN ? {mem_rdata[7:0], b0_q} : {b0_q, mem_rdata[7:0]};
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      size_q       <= 1'b0;
      signed_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      b0_q         <= '0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      b0_q         <= b0_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed checks of dmem_ctrl against a byte-wide memory model.
module tb_dmem_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_size = 1'b0, req_signed = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, mem_we, mem_re;
  logic [15:0] resp_rdata, mem_addr, mem_rdata = '0;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem [0:65535];
  int          total = 0, bad = 0, we_cnt = 0;
  logic        conflict = 1'b0;

  dmem_ctrl #(.ADDR_W(16), .LITTLE_ENDIAN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Registered-read memory; the high byte of mem_rdata is junk the controller must ignore.
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (mem_re) mem_rdata <= {8'hA5, mem[mem_addr]};
  end

  always @(negedge clk) if (mem_we && mem_re) conflict = 1'b1;

  // lat = number of negedges after the accept edge until resp_valid is seen, i.e. N.
  task automatic do_req(input logic we, input logic sz, input logic sg, input logic [15:0] a,
                        input logic [15:0] wd, output int lat, output logic [15:0] rd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1;
    rd = 16'hxxxx;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = n;
        rd = resp_rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({req_ready, resp_valid, resp_rdata, mem_addr, mem_wdata, mem_we, mem_re} !== {1'b1, 1'b0, 16'h0, 16'h0, 8'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset: got ready=%b rv=%b rd=%h ma=%h mw=%h we=%b re=%b want 1 0 0000 0000 00 0 0",
               req_ready, resp_valid, resp_rdata, mem_addr, mem_wdata, mem_we, mem_re);
    end
    rst = 1'b0;
  endtask

  task automatic test_store_byte();
    int lat, w0;
    logic [15:0] rd;
    w0 = we_cnt;
    do_req(1'b1, 1'b0, 1'b0, 16'h0010, 16'h12AB, lat, rd);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL sb_latency: got %0d want 2", lat); end
    total++;
    if (mem[16'h0010] !== 8'hAB) begin bad++; $display("FAIL sb_data: got %h want ab", mem[16'h0010]); end
    total++;
    if (we_cnt - w0 !== 1) begin bad++; $display("FAIL sb_we_count: got %0d want 1", we_cnt - w0); end
    total++;
    if (rd !== 16'h0000) begin bad++; $display("FAIL sb_rdata_kept: got %h want 0000", rd); end
  endtask

  task automatic test_half_roundtrip();
    int lat, w0;
    logic [15:0] rd;
    w0 = we_cnt;
    do_req(1'b1, 1'b1, 1'b0, 16'h0020, 16'hBEEF, lat, rd);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL sh_latency: got %0d want 3", lat); end
    total++;
    if ({mem[16'h0021], mem[16'h0020]} !== 16'hBEEF) begin
      bad++; $display("FAIL sh_data: got %h%h want beef", mem[16'h0021], mem[16'h0020]);
    end
    total++;
    if (we_cnt - w0 !== 2) begin bad++; $display("FAIL sh_we_count: got %0d want 2", we_cnt - w0); end
    do_req(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, lat, rd);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL lh_latency: got %0d want 4", lat); end
    total++;
    if (rd !== 16'hBEEF) begin bad++; $display("FAIL lh_data: got %h want beef", rd); end
  endtask

  task automatic test_sign_ext();
    int lat;
    logic [15:0] rd;
    do_req(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0080, lat, rd);
    do_req(1'b0, 1'b0, 1'b1, 16'h0030, 16'h0000, lat, rd);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL lb_latency: got %0d want 3", lat); end
    total++;
    if (rd !== 16'hFF80) begin bad++; $display("FAIL lb_signed: got %h want ff80", rd); end
    do_req(1'b0, 1'b0, 1'b0, 16'h0030, 16'h0000, lat, rd);
    total++;
    if (rd !== 16'h0080) begin bad++; $display("FAIL lb_unsigned: got %h want 0080", rd); end
  endtask

  task automatic test_wrap();
    int lat;
    logic [15:0] rd;
    do_req(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h1234, lat, rd);
    total++;
    if ({mem[16'h0000], mem[16'hFFFF]} !== 16'h1234) begin
      bad++; $display("FAIL wrap_store: got %h%h want 1234", mem[16'h0000], mem[16'hFFFF]);
    end
    do_req(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, lat, rd);
    total++;
    if (rd !== 16'h1234) begin bad++; $display("FAIL wrap_load: got %h want 1234", rd); end
  endtask

  task automatic test_reset_mid();
    int lat, seen;
    logic [15:0] rd;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 1'b1; req_signed = 1'b0; req_addr = 16'h0040; req_wdata = 16'h5678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if ({req_ready, resp_valid, resp_rdata, mem_addr, mem_wdata, mem_we, mem_re} !== {1'b1, 1'b0, 16'h0, 16'h0, 8'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL rst_mid_outputs: got ready=%b rv=%b rd=%h ma=%h mw=%h we=%b re=%b want 1 0 0000 0000 00 0 0",
               req_ready, resp_valid, resp_rdata, mem_addr, mem_wdata, mem_we, mem_re);
    end
    seen = 0;
    repeat (2) begin @(negedge clk); if (resp_valid) seen++; end
    rst = 1'b0;
    repeat (4) begin @(negedge clk); if (resp_valid) seen++; end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL rst_mid_no_resp: got %0d pulses want 0", seen); end
    do_req(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, lat, rd);
    total++;
    if (rd !== 16'h0078) begin bad++; $display("FAIL rst_mid_byte0: got %h want 0078", rd); end
    do_req(1'b0, 1'b0, 1'b0, 16'h0041, 16'h0000, lat, rd);
    total++;
    if (rd !== 16'h005C) begin bad++; $display("FAIL rst_mid_byte1: got %h want 005c", rd); end
  endtask

  // Held request: each halfword load takes LD0,LD1,LD2,RESP then one IDLE cycle.
  task automatic test_back_to_back();
    @(negedge clk);
    conflict = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 1'b1; req_signed = 1'b0; req_addr = 16'h0020;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 9) req_valid = 1'b0;
      total++;
      if (req_ready !== (i % 5 == 4)) begin
        bad++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, req_ready, i % 5 == 4);
      end
      total++;
      if (resp_valid !== (i % 5 == 3)) begin
        bad++; $display("FAIL b2b_resp[%0d]: got %b want %b", i, resp_valid, i % 5 == 3);
      end
      if (i % 5 == 3) begin
        total++;
        if (resp_rdata !== 16'hBEEF) begin bad++; $display("FAIL b2b_data[%0d]: got %h want beef", i, resp_rdata); end
      end
    end
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle: got %b want 1", req_ready); end
    total++;
    if (conflict !== 1'b0) begin bad++; $display("FAIL we_re_overlap: got %b want 0", conflict); end
  endtask

  initial begin
    mem[16'h0041] = 8'h5C;
    test_reset();
    test_store_byte();
    test_half_roundtrip();
    test_sign_ext();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
